// File: rtl/mem_block_fetcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mem_block_fetcher
//  Purpose  : Instruction-cache block-fill engine. Accepts a fill request from
//             the miss handler, issues one memory request, and assembles a
//             block of BEATS_PER_BLOCK beats. Beats arrive critical-beat first
//             and wrap around the block. The critical beat is exposed early
//             (early restart). A per-beat mask shows which slots are written.
//             A synchronous flush cancels any fill.
//  Ports    : clk, arst_n                  - clock, async active-low reset
//             i_halt, i_flush              - global freeze / cancel
//             i_block_addr, i_req_word,
//             i_req_valid, o_req_ready     - fill request from miss handler
//             o_mem_req_*, i_mem_req_ready - memory request channel
//             i_mem_data*, o_mem_ready     - memory beat channel
//             o_block_data, o_beat_mask,
//             o_num_words_rcvd             - assembled block and progress
//             o_crit_data, o_crit_valid    - early-restart critical beat
//             o_block_valid, o_busy        - completion pulse / activity
//  Revision : 1.0 - initial release
// ============================================================================
module mem_block_fetcher #(
  parameter int ADDR_WIDTH      = 16,
  parameter int MEM_DATA_WIDTH  = 40,
  parameter int BEATS_PER_BLOCK = 8,
  parameter int WORDS_PER_BEAT  = 2,
  localparam int BW = $clog2(BEATS_PER_BLOCK),
  localparam int WW = $clog2(BEATS_PER_BLOCK * WORDS_PER_BEAT)
) (
  input  logic                                  clk,
  input  logic                                  arst_n,
  input  logic                                  i_halt,
  input  logic                                  i_flush,
  input  logic [ADDR_WIDTH-1:0]                 i_block_addr,
  input  logic [WW-1:0]                         i_req_word,
  input  logic                                  i_req_valid,
  output logic                                  o_req_ready,
  output logic [ADDR_WIDTH-1:0]                 o_mem_req_addr,
  output logic [BW-1:0]                         o_mem_req_start_beat,
  output logic                                  o_mem_req_valid,
  input  logic                                  i_mem_req_ready,
  input  logic [MEM_DATA_WIDTH-1:0]             i_mem_data,
  input  logic                                  i_mem_data_valid,
  output logic                                  o_mem_ready,
  output logic [MEM_DATA_WIDTH*BEATS_PER_BLOCK-1:0] o_block_data,
  output logic [BEATS_PER_BLOCK-1:0]            o_beat_mask,
  output logic [WW:0]                           o_num_words_rcvd,
  output logic [MEM_DATA_WIDTH-1:0]             o_crit_data,
  output logic                                  o_crit_valid,
  output logic                                  o_block_valid,
  output logic                                  o_busy
);

  // Word-index bits below the beat index.
  localparam int c_word_lsb = $clog2(WORDS_PER_BEAT);
  // Counter value that the final beat of a block is accepted at.
  localparam logic [BW:0] c_cnt_last = (BW+1)'(BEATS_PER_BLOCK - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RECV = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_WIDTH-1:0]                     r_addr;
  logic [BW-1:0]                             r_start;
  logic [BW-1:0]                             r_ptr;
  logic [BW:0]                               r_cnt;
  logic [BEATS_PER_BLOCK-1:0]                r_mask;
  logic [MEM_DATA_WIDTH*BEATS_PER_BLOCK-1:0] r_block;
  logic [MEM_DATA_WIDTH-1:0]                 r_crit;
  logic                                      r_crit_valid;

  // Handshake events; flush and halt both veto every transfer.
  logic w_req_fire;
  logic w_memreq_fire;
  logic w_beat_fire;
  logic w_last_beat;

  assign w_req_fire    = (r_state == ST_IDLE) & i_req_valid      & ~i_halt & ~i_flush;
  assign w_memreq_fire = (r_state == ST_REQ)  & i_mem_req_ready  & ~i_halt & ~i_flush;
  assign w_beat_fire   = (r_state == ST_RECV) & i_mem_data_valid & ~i_halt & ~i_flush;
  assign w_last_beat   = w_beat_fire & (r_cnt == c_cnt_last);

  always_comb begin
    w_next          = r_state;
    o_req_ready     = 1'b0;
    o_mem_req_valid = 1'b0;
    o_mem_ready     = 1'b0;
    o_block_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_req_ready = ~i_halt;
        if (w_req_fire) w_next = ST_REQ;
      end
      ST_REQ: begin
        // Held through halt, but only counts as accepted when not halted.
        o_mem_req_valid = 1'b1;
        if (w_memreq_fire) w_next = ST_RECV;
      end
      ST_RECV: begin
        o_mem_ready = ~i_halt;
        if (w_last_beat) w_next = ST_DONE;
      end
      ST_DONE: begin
        o_block_valid = 1'b1;
        if (!i_halt) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    if (i_flush) w_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_addr       <= '0;
      r_start      <= '0;
      r_ptr        <= '0;
      r_cnt        <= '0;
      r_mask       <= '0;
      r_block      <= '0;
      r_crit       <= '0;
      r_crit_valid <= 1'b0;
    end else if (i_flush) begin
      r_cnt        <= '0;
      r_mask       <= '0;
      r_crit_valid <= 1'b0;
    end else if (w_req_fire) begin
      // Block data is deliberately left alone until slots are overwritten.
      r_addr       <= i_block_addr;
      r_start      <= BW'(i_req_word >> c_word_lsb);
      r_ptr        <= BW'(i_req_word >> c_word_lsb);
      r_cnt        <= '0;
      r_mask       <= '0;
      r_crit_valid <= 1'b0;
    end else if (w_beat_fire) begin
      r_block[r_ptr*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] <= i_mem_data;
      r_mask[r_ptr] <= 1'b1;
      r_ptr         <= r_ptr + 1'b1;  // wraps at BW bits
      r_cnt         <= r_cnt + 1'b1;
      if (r_cnt == '0) begin
        r_crit       <= i_mem_data;
        r_crit_valid <= 1'b1;
      end
    end
  end

  assign o_mem_req_addr       = r_addr;
  assign o_mem_req_start_beat = r_start;
  assign o_block_data         = r_block;
  assign o_beat_mask          = r_mask;
  assign o_num_words_rcvd     = (WW+1)'(r_cnt) << c_word_lsb;
  assign o_crit_data          = r_crit;
  assign o_crit_valid         = r_crit_valid;
  assign o_busy               = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_block_fetcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mem_block_fetcher
//  Purpose  : Self-checking bench for mem_block_fetcher. Randomised fills are
//             driven against a block-level reference model; a scoreboard
//             monitor compares the critical beat and the completed block
//             whenever the design presents them. A second instance checks a
//             smaller parametrisation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_block_fetcher;
  localparam int AW = 16, DW = 40, NB = 8, WPB = 2, BW = 3, WW = 4;
  localparam int DW4 = 32, NB4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic arst_n, halt, flush;
  logic [AW-1:0] block_addr, mem_req_addr;
  logic [WW-1:0] req_word;
  logic req_valid, req_ready, mem_req_valid, mem_req_ready;
  logic [BW-1:0] start_beat;
  logic [DW-1:0] mem_data, crit_data;
  logic mem_data_valid, mem_ready, crit_valid, block_valid, busy;
  logic [DW*NB-1:0] block_data;
  logic [NB-1:0] beat_mask;
  logic [WW:0] num_words;

  logic [AW-1:0] block_addr4, mem_req_addr4;
  logic [1:0] req_word4, start4;
  logic req_valid4, req_ready4, mem_req_valid4, mem_req_ready4;
  logic [DW4-1:0] mem_data4, crit4;
  logic mem_data_valid4, mem_ready4, crit_valid4, block_valid4, busy4;
  logic [DW4*NB4-1:0] block_data4;
  logic [NB4-1:0] mask4;
  logic [2:0] num_words4;

  mem_block_fetcher #(.ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW), .BEATS_PER_BLOCK(NB),
                      .WORDS_PER_BEAT(WPB)) u_dut (
    .clk(clk), .arst_n(arst_n), .i_halt(halt), .i_flush(flush),
    .i_block_addr(block_addr), .i_req_word(req_word), .i_req_valid(req_valid),
    .o_req_ready(req_ready), .o_mem_req_addr(mem_req_addr),
    .o_mem_req_start_beat(start_beat), .o_mem_req_valid(mem_req_valid),
    .i_mem_req_ready(mem_req_ready), .i_mem_data(mem_data),
    .i_mem_data_valid(mem_data_valid), .o_mem_ready(mem_ready),
    .o_block_data(block_data), .o_beat_mask(beat_mask),
    .o_num_words_rcvd(num_words), .o_crit_data(crit_data),
    .o_crit_valid(crit_valid), .o_block_valid(block_valid), .o_busy(busy));

  mem_block_fetcher #(.ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW4), .BEATS_PER_BLOCK(NB4),
                      .WORDS_PER_BEAT(1)) u_dut4 (
    .clk(clk), .arst_n(arst_n), .i_halt(halt), .i_flush(flush),
    .i_block_addr(block_addr4), .i_req_word(req_word4), .i_req_valid(req_valid4),
    .o_req_ready(req_ready4), .o_mem_req_addr(mem_req_addr4),
    .o_mem_req_start_beat(start4), .o_mem_req_valid(mem_req_valid4),
    .i_mem_req_ready(mem_req_ready4), .i_mem_data(mem_data4),
    .i_mem_data_valid(mem_data_valid4), .o_mem_ready(mem_ready4),
    .o_block_data(block_data4), .o_beat_mask(mask4),
    .o_num_words_rcvd(num_words4), .o_crit_data(crit4),
    .o_crit_valid(crit_valid4), .o_block_valid(block_valid4), .o_busy(busy4));

  int passed = 0, total = 0;

  // Reference model: contents of each block slot, plus scoreboard queues.
  logic [DW-1:0]    model [NB];
  logic [DW-1:0]    crit_q [$];
  logic [DW*NB-1:0] blk_q  [$];

  task automatic chk(input string name, input logic [DW*NB-1:0] act, input logic [DW*NB-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    total++;
    $display("FAIL %s: actual=event occurred required=no event", name);
  endtask

  function automatic logic [DW*NB-1:0] flat_model();
    logic [DW*NB-1:0] f;
    for (int k = 0; k < NB; k++) f[k*DW +: DW] = model[k];
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compares whenever the design presents its outputs.
  logic prev_crit = 1'b0, prev_bv = 1'b0;
  always @(negedge clk) begin
    if (crit_valid && !prev_crit) begin
      if (crit_q.size() == 0) fail_now("crit_unexpected");
      else chk("crit_data", crit_data, crit_q.pop_front());
    end
    if (block_valid && !prev_bv) begin
      if (blk_q.size() == 0) fail_now("block_unexpected");
      else begin
        chk("block_data", block_data, blk_q.pop_front());
        chk("block_mask", beat_mask, {NB{1'b1}});
        chk("block_words", num_words, NB * WPB);
      end
    end
    if (prev_bv && !halt) chk("block_valid_pulse", block_valid, 1'b0);
    prev_crit <= crit_valid;
    prev_bv   <= block_valid;
  end

  // One fill. base!=0 gives beats base, base+1, ...; otherwise random data.
  // abort_kind: 0 none, 1 flush after abort_at beats, 2 reset after abort_at.
  task automatic do_fill(input logic [AW-1:0] addr, input logic [WW-1:0] word,
                         input int base, input int stall, input int halt_at,
                         input int abort_at, input int abort_kind, input bit bubbles);
    logic [DW-1:0] d [NB];
    logic [NB-1:0] emask;
    int s, nb, t;
    s  = int'(word) / WPB;
    nb = (abort_kind != 0) ? abort_at : NB;
    for (int i = 0; i < NB; i++)
      d[i] = (base != 0) ? DW'(base + i) : DW'({$urandom(), $urandom()});

    block_addr = addr; req_word = word; req_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    if (!req_ready) begin fail_now("req_timeout"); req_valid = 1'b0; return; end
    step();
    req_valid = 1'b0;
    chk("memreq_valid", mem_req_valid, 1'b1);
    chk("memreq_addr", mem_req_addr, addr);
    chk("memreq_start", start_beat, s);
    chk("mask_cleared", beat_mask, 0);
    chk("crit_cleared", crit_valid, 1'b0);
    for (int k = 0; k < stall; k++) begin
      step();
      chk("stall_valid", mem_req_valid, 1'b1);
      chk("stall_addr", mem_req_addr, addr);
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;

    if (nb > 0) crit_q.push_back(d[0]);
    for (int i = 0; i < nb; i++) model[(s + i) % NB] = d[i];
    if (abort_kind == 0) blk_q.push_back(flat_model());

    emask = '0;
    for (int i = 0; i < nb; i++) begin
      if (bubbles) begin
        mem_data_valid = 1'b0;
        repeat ($urandom_range(0, 2)) step();
      end
      mem_data = d[i]; mem_data_valid = 1'b1;
      if (i == halt_at) begin
        halt = 1'b1;
        for (int h = 0; h < 3; h++) begin
          @(negedge clk);
          chk("halt_mem_ready", mem_ready, 1'b0);
          chk("halt_words", num_words, i * WPB);
          step();
        end
        halt = 1'b0;
      end
      t = 0;
      @(negedge clk);
      while (!mem_ready && t < 20) begin @(negedge clk); t++; end
      if (!mem_ready) begin fail_now("beat_timeout"); mem_data_valid = 1'b0; return; end
      step();
      emask[(s + i) % NB] = 1'b1;
      chk("beat_mask", beat_mask, emask);
      chk("beat_words", num_words, (i + 1) * WPB);
      if (i == 0) chk("crit_early", crit_valid, 1'b1);
    end
    mem_data_valid = 1'b0;

    if (abort_kind == 0) begin
      chk("done_valid", block_valid, 1'b1);
      step();
      chk("idle_ready", req_ready, 1'b1);
    end else if (abort_kind == 1) begin
      flush = 1'b1; mem_data = DW'({$urandom(), $urandom()}); mem_data_valid = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_busy", busy, 1'b0);
      chk("flush_mask", beat_mask, 0);
      chk("flush_crit", crit_valid, 1'b0);
      chk("flush_words", num_words, 0);
      repeat (3) step();
      chk("drop_mask", beat_mask, 0);
      chk("drop_data", block_data, flat_model());
      mem_data_valid = 1'b0;
      req_valid = 1'b1; flush = 1'b1;
      step();
      req_valid = 1'b0; flush = 1'b0;
      chk("flush_blocks_req", busy, 1'b0);
    end else begin
      arst_n = 1'b0;
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_data", block_data, 0);
      chk("rst_mask", beat_mask, 0);
      chk("rst_crit", {crit_valid, crit_data}, 0);
      chk("rst_req_ready", req_ready, 1'b1);
      for (int k = 0; k < NB; k++) model[k] = '0;
      step();
      arst_n = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    arst_n = 1'b0; halt = 0; flush = 0; block_addr = '0; req_word = '0; req_valid = 0;
    mem_req_ready = 0; mem_data = '0; mem_data_valid = 0;
    block_addr4 = '0; req_word4 = '0; req_valid4 = 0; mem_req_ready4 = 0;
    mem_data4 = '0; mem_data_valid4 = 0;
    for (int k = 0; k < NB; k++) model[k] = '0;
    step(); step();
    arst_n = 1'b1;
    step();

    chk("reset_req_ready", req_ready, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_mem_req_valid", mem_req_valid, 1'b0);
    chk("reset_mem_ready", mem_ready, 1'b0);
    chk("reset_block_data", block_data, 0);
    chk("reset_mask_words", {beat_mask, num_words}, 0);
    chk("reset_crit", {crit_valid, crit_data}, 0);
    chk("reset_block_valid", block_valid, 1'b0);
    halt = 1'b1;
    #1;
    chk("halt_req_ready", req_ready, 1'b0);
    halt = 1'b0;

    do_fill(16'h1230, 4'd0,  32'h01, 0, -1, 0, 0, 1'b0);  // ordered fill
    do_fill(16'h4560, 4'd11, 32'h0A, 0, -1, 0, 0, 1'b0);  // wrap fill
    do_fill(AW'($urandom), WW'($urandom), 0, 4, 2, 0, 0, 1'b1);  // stall + halt
    do_fill(AW'($urandom), WW'($urandom), 0, 0, -1, 3, 1, 1'b0); // flush
    do_fill(AW'($urandom), WW'($urandom), 0, 0, -1, 0, 0, 1'b1);
    do_fill(AW'($urandom), WW'($urandom), 0, 1, -1, 2, 2, 1'b0); // reset
    do_fill(AW'($urandom), WW'($urandom), 0, 0, -1, 0, 0, 1'b0);
    for (int n = 0; n < 8; n++)
      do_fill(AW'($urandom), WW'($urandom), 0, $urandom_range(0, 2),
              $urandom_range(0, 9), 0, 0, 1'b1);

    // Smaller parametrisation: 4 beats, one word per beat, 32-bit beats.
    block_addr4 = 16'h0040; req_word4 = 2'd0; req_valid4 = 1'b1;
    @(negedge clk);
    chk("p4_req_ready", req_ready4, 1'b1);
    step();
    req_valid4 = 1'b0;
    chk("p4_memreq", mem_req_valid4, 1'b1);
    chk("p4_start", start4, 0);
    mem_req_ready4 = 1'b1;
    step();
    mem_req_ready4 = 1'b0;
    for (int i = 0; i < NB4; i++) begin
      mem_data4 = DW4'(i + 1); mem_data_valid4 = 1'b1;
      @(negedge clk);
      chk("p4_mem_ready", mem_ready4, 1'b1);
      step();
      if (i < NB4 - 1) chk("p4_early_bv", block_valid4, 1'b0);
    end
    mem_data_valid4 = 1'b0;
    chk("p4_bv", block_valid4, 1'b1);
    chk("p4_words", num_words4, 4);
    chk("p4_data", block_data4, {32'd4, 32'd3, 32'd2, 32'd1});
    chk("p4_mask_crit", {mask4, crit4}, {4'hF, 32'd1});
    step();
    chk("p4_idle", {req_ready4, block_valid4}, 2'b10);

    repeat (3) step();
    chk("crit_q_drain", crit_q.size(), 0);
    chk("blk_q_drain", blk_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
